// File: rtl/adma_pkg.sv
// rtl/adma_pkg.sv - shared types and AXI response encodings for the ADMA data mover
package adma_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

endpackage

// File: rtl/adma_rr_arb.sv
// rtl/adma_rr_arb.sv - combinational round-robin pick starting at a pointer
module adma_rr_arb #(
    parameter int CH_NUM = 4,
    parameter int IDX_W  = $clog2(CH_NUM)
) (
    input  logic [CH_NUM-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [CH_NUM-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_gnt_idx,
    output logic              o_gnt_vld
);

    always_comb begin
        int j;
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        j         = 0;
        // Scan from the pointer upward, wrapping past the last channel.
        for (int i = 0; i < CH_NUM; i++) begin
            j = int'(i_ptr) + i;
            if (j >= CH_NUM) begin
                j = j - CH_NUM;
            end
            if (!o_gnt_vld && i_req[j]) begin
                o_gnt_vld = 1'b1;
                o_gnt[j]  = 1'b1;
                o_gnt_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/adma_dm_aw_sched.sv
// rtl/adma_dm_aw_sched.sv - write burst scheduler: channel arbitration, AW issue, W mover push, B routing
module adma_dm_aw_sched
    import adma_pkg::*;
#(
    parameter int CH_NUM       = 4,
    parameter int ATX_ID_W     = 2,
    parameter int ATX_ADDR_W   = 32,
    parameter int ATX_LEN_W    = 8,
    parameter int ATX_NUM_OSTD = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [CH_NUM*ATX_ADDR_W-1:0]         ch_awaddr,
    input  logic [CH_NUM*ATX_LEN_W-1:0]          ch_awlen,
    input  logic [CH_NUM-1:0]                    ch_aw_vld,
    output logic [CH_NUM-1:0]                    ch_aw_rdy,
    output logic [CH_NUM-1:0]                    ch_done,
    output logic [CH_NUM-1:0]                    ch_err,
    output logic [ATX_LEN_W-1:0]                 atx_awlen,
    output logic                                 atx_vld,
    input  logic                                 atx_rdy,
    output logic [ATX_ID_W-1:0]                  m_awid_o,
    output logic [ATX_ADDR_W-1:0]                m_awaddr_o,
    output logic [ATX_LEN_W-1:0]                 m_awlen_o,
    output logic                                 m_awvalid_o,
    input  logic                                 m_awready_i,
    input  logic [ATX_ID_W-1:0]                  m_bid_i,
    input  logic [1:0]                           m_bresp_i,
    input  logic                                 m_bvalid_i,
    output logic                                 m_bready_o,
    output logic [$clog2(ATX_NUM_OSTD+1)-1:0]    ostd_cnt,
    output logic                                 unexp_b_err
);

    localparam int IDX_W = $clog2(CH_NUM);
    localparam int CNT_W = $clog2(ATX_NUM_OSTD+1);

    sched_state_t           r_state;
    sched_state_t           w_state_nxt;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [CH_NUM-1:0]      w_gnt;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic                   w_gnt_vld;
    logic                   w_grant;
    logic                   w_aw_hs;
    logic                   w_atx_hs;
    logic                   w_b_hs;
    logic                   w_b_err;
    logic                   w_b_id_ok;
    logic                   w_ostd_inc;
    logic                   w_ostd_dec;
    logic [CH_NUM-1:0]      w_b_dec;
    logic [ATX_ADDR_W-1:0]  w_sel_addr;
    logic [ATX_LEN_W-1:0]   w_sel_len;

    logic [ATX_ID_W-1:0]    r_awid;
    logic [ATX_ADDR_W-1:0]  r_awaddr;
    logic [ATX_LEN_W-1:0]   r_awlen;
    logic [ATX_LEN_W-1:0]   r_atx_len;
    logic                   r_awvalid;
    logic                   r_atx_vld;
    logic                   r_bready;
    logic [CNT_W-1:0]       r_ostd;
    logic [CH_NUM-1:0]      r_done;
    logic [CH_NUM-1:0]      r_err;
    logic                   r_unexp;

    adma_rr_arb #(
        .CH_NUM (CH_NUM),
        .IDX_W  (IDX_W)
    ) u_arb (
        .i_req     (ch_aw_vld),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    // The limit check uses the registered count, so a same-cycle B frees nothing yet.
    assign w_grant    = (r_state == IDLE) && w_gnt_vld && (r_ostd < CNT_W'(ATX_NUM_OSTD));
    assign w_aw_hs    = r_awvalid && m_awready_i;
    assign w_atx_hs   = r_atx_vld && atx_rdy;
    assign w_b_hs     = m_bvalid_i && r_bready;
    assign w_b_err    = (m_bresp_i == BRESP_SLVERR) || (m_bresp_i == BRESP_DECERR);
    assign w_b_id_ok  = int'(m_bid_i) < CH_NUM;
    assign w_ostd_inc = w_aw_hs;
    assign w_ostd_dec = w_b_hs && (r_ostd != '0);

    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        w_b_dec    = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = ch_awaddr[i*ATX_ADDR_W +: ATX_ADDR_W];
                w_sel_len  = ch_awlen[i*ATX_LEN_W +: ATX_LEN_W];
            end
            w_b_dec[i] = w_b_hs && (int'(m_bid_i) == i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if ((w_aw_hs || !r_awvalid) && (w_atx_hs || !r_atx_vld)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_atx_len <= '0;
            r_awvalid <= 1'b0;
            r_atx_vld <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_rr_ptr  <= (int'(w_gnt_idx) == CH_NUM-1) ? '0 : w_gnt_idx + 1'b1;
                r_awid    <= ATX_ID_W'(w_gnt_idx);
                r_awaddr  <= w_sel_addr;
                r_awlen   <= w_sel_len;
                r_atx_len <= w_sel_len;
                r_awvalid <= 1'b1;
                r_atx_vld <= 1'b1;
            end else begin
                if (w_aw_hs) begin
                    r_awvalid <= 1'b0;
                end
                if (w_atx_hs) begin
                    r_atx_vld <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bready <= 1'b0;
            r_ostd   <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_unexp  <= 1'b0;
        end else begin
            r_bready <= 1'b1;
            if (w_ostd_inc && !w_ostd_dec) begin
                r_ostd <= r_ostd + 1'b1;
            end else if (!w_ostd_inc && w_ostd_dec) begin
                r_ostd <= r_ostd - 1'b1;
            end
            r_done <= w_b_dec;
            r_err  <= w_b_err ? w_b_dec : '0;
            if (w_b_hs && ((r_ostd == '0) || !w_b_id_ok)) begin
                r_unexp <= 1'b1;
            end
        end
    end

    assign ch_aw_rdy   = w_grant ? w_gnt : '0;
    assign ch_done     = r_done;
    assign ch_err      = r_err;
    assign atx_awlen   = r_atx_len;
    assign atx_vld     = r_atx_vld;
    assign m_awid_o    = r_awid;
    assign m_awaddr_o  = r_awaddr;
    assign m_awlen_o   = r_awlen;
    assign m_awvalid_o = r_awvalid;
    assign m_bready_o  = r_bready;
    assign ostd_cnt    = r_ostd;
    assign unexp_b_err = r_unexp;

endmodule

// File: tb/tb_adma_dm_aw_sched.sv
// tb/tb_adma_dm_aw_sched.sv - directed and randomized bench for the AW scheduler
module tb_adma_dm_aw_sched;

    localparam int CH  = 4;
    localparam int AW  = 32;
    localparam int LW  = 8;
    localparam int IDW = 2;
    localparam int NO  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH*AW-1:0]  ch_awaddr;
    logic [CH*LW-1:0]  ch_awlen;
    logic [CH-1:0]     ch_aw_vld;
    logic [CH-1:0]     ch_aw_rdy;
    logic [CH-1:0]     ch_done;
    logic [CH-1:0]     ch_err;
    logic [LW-1:0]     atx_awlen;
    logic              atx_vld;
    logic              atx_rdy;
    logic [IDW-1:0]    m_awid_o;
    logic [AW-1:0]     m_awaddr_o;
    logic [LW-1:0]     m_awlen_o;
    logic              m_awvalid_o;
    logic              m_awready_i;
    logic [IDW-1:0]    m_bid_i;
    logic [1:0]        m_bresp_i;
    logic              m_bvalid_i;
    logic              m_bready_o;
    logic [2:0]        ostd_cnt;
    logic              unexp_b_err;

    always #5 clk = ~clk;

    adma_dm_aw_sched #(
        .CH_NUM(CH), .ATX_ID_W(IDW), .ATX_ADDR_W(AW), .ATX_LEN_W(LW), .ATX_NUM_OSTD(NO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_awaddr(ch_awaddr), .ch_awlen(ch_awlen), .ch_aw_vld(ch_aw_vld), .ch_aw_rdy(ch_aw_rdy),
        .ch_done(ch_done), .ch_err(ch_err),
        .atx_awlen(atx_awlen), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
        .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o),
        .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
        .ostd_cnt(ostd_cnt), .unexp_b_err(unexp_b_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one burst in flight at most, outstanding IDs kept as a list.
    bit          m_aw_pend;
    bit          m_atx_pend;
    int          m_id;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    int          m_ptr;
    int          ostd_q[$];
    logic [3:0]  m_done;
    logic [3:0]  m_err;
    bit          m_unexp;
    int          last_g;
    logic [3:0]  hold;
    logic [3:0]  obs_gnt[9];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic [31:0] a, input logic [7:0] l);
        ch_awaddr[c*AW +: AW] = a;
        ch_awlen[c*LW +: LW]  = l;
    endtask

    function automatic int pick();
        if (m_aw_pend || m_atx_pend || ostd_q.size() >= NO) return -1;
        for (int i = 0; i < CH; i++) begin
            if (ch_aw_vld[(m_ptr + i) % CH]) return (m_ptr + i) % CH;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_aw_pend = 0; m_atx_pend = 0; m_id = 0; m_addr = '0; m_len = '0;
        m_ptr = 0; ostd_q.delete(); m_done = '0; m_err = '0; m_unexp = 0; last_g = -1;
    endtask

    task automatic auto_b();
        if (ostd_q.size() > 0) begin
            m_bvalid_i = 1'b1; m_bid_i = IDW'(ostd_q[0]); m_bresp_i = 2'b00;
        end else begin
            m_bvalid_i = 1'b0;
        end
    endtask

    task automatic cyc();
        int g;
        int b;
        int idx;
        logic [3:0] e;
        @(negedge clk);
        g = pick();
        e = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("aw_rdy", ch_aw_rdy, e);
        chk("awvalid", m_awvalid_o, m_aw_pend);
        chk("atx_vld", atx_vld, m_atx_pend);
        if (m_aw_pend) begin
            chk("awid", m_awid_o, m_id);
            chk("awaddr", m_awaddr_o, m_addr);
            chk("awlen", m_awlen_o, m_len);
        end
        if (m_atx_pend) chk("atx_awlen", atx_awlen, m_len);
        chk("ostd_cnt", ostd_cnt, ostd_q.size());
        chk("ch_done", ch_done, m_done);
        chk("ch_err", ch_err, m_err);
        chk("unexp_b_err", unexp_b_err, m_unexp);
        chk("bready", m_bready_o, 1);
        @(posedge clk);
        m_done = '0;
        m_err  = '0;
        if (m_bvalid_i) begin
            b = int'(m_bid_i);
            if (ostd_q.size() == 0 || b >= CH) m_unexp = 1;
            if (b < CH) begin
                m_done[b] = 1'b1;
                m_err[b]  = m_bresp_i[1];
            end
            if (ostd_q.size() > 0) begin
                idx = -1;
                for (int i = 0; i < ostd_q.size(); i++) if (idx < 0 && ostd_q[i] == b) idx = i;
                if (idx < 0) idx = 0;
                ostd_q.delete(idx);
            end
        end
        if (m_aw_pend && m_awready_i) begin
            ostd_q.push_back(m_id);
            m_aw_pend = 0;
        end
        if (m_atx_pend && atx_rdy) m_atx_pend = 0;
        if (g >= 0) begin
            m_aw_pend = 1; m_atx_pend = 1; m_id = g;
            m_addr = ch_awaddr[g*AW +: AW];
            m_len  = ch_awlen[g*LW +: LW];
            m_ptr  = (g + 1) % CH;
        end
        last_g = g;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ch_aw_vld = '0; m_awready_i = 0; atx_rdy = 0; m_bvalid_i = 0; m_bid_i = '0; m_bresp_i = '0;
        @(negedge clk);
        chk("rst_awvalid", m_awvalid_o, 0);
        chk("rst_atx_vld", atx_vld, 0);
        chk("rst_ostd", ostd_cnt, 0);
        chk("rst_unexp", unexp_b_err, 0);
        chk("rst_done", ch_done, 0);
        chk("rst_err", ch_err, 0);
        chk("rst_bready", m_bready_o, 0);
        chk("rst_awaddr", m_awaddr_o, 0);
        chk("rst_atx_len", atx_awlen, 0);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ch_awaddr = '0; ch_awlen = '0; hold = '0;
        do_reset();

        // Single request on channel 1
        set_ch(1, 32'h1000, 8'd7);
        ch_aw_vld = 4'b0010; m_awready_i = 1; atx_rdy = 1;
        #1 chk("single_rdy_t", ch_aw_rdy, 4'b0010);
        cyc();
        ch_aw_vld = '0;
        chk("single_awid", m_awid_o, 1);
        chk("single_awaddr", m_awaddr_o, 32'h1000);
        chk("single_awlen", m_awlen_o, 7);
        chk("single_atx_len", atx_awlen, 7);
        chk("single_awvalid", m_awvalid_o, 1);
        cyc();
        chk("single_ostd", ostd_cnt, 1);
        chk("single_awvalid_low", m_awvalid_o, 0);
        set_ch(2, 32'h2000, 8'd3);
        ch_aw_vld = 4'b0100;
        #1 chk("single_idle_t2", ch_aw_rdy, 4'b0100);
        cyc();
        ch_aw_vld = '0;
        cyc(); cyc();

        // Fairness with all channels requesting
        do_reset();
        for (int c = 0; c < CH; c++) set_ch(c, $urandom, 8'($urandom));
        ch_aw_vld = 4'hf; m_awready_i = 1; atx_rdy = 1;
        for (int k = 0; k < 9; k++) begin
            auto_b();
            #1 obs_gnt[k] = ch_aw_rdy;
            cyc();
        end
        for (int k = 0; k < 9; k++) begin
            chk("fair_gnt", obs_gnt[k], (k % 2 == 0) ? (4'b0001 << ((k / 2) % 4)) : 4'b0000);
        end
        ch_aw_vld = '0; m_bvalid_i = 0;
        cyc(); cyc();

        // Skewed handshakes: AW first, then atx at t+4
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            set_ch(0, 32'h4000 + mode, 8'd15);
            set_ch(2, 32'h8000, 8'd1);
            ch_aw_vld = 4'b0001;
            m_awready_i = (mode == 0); atx_rdy = (mode == 1);
            cyc();
            ch_aw_vld = '0;
            cyc();
            chk("skew_awvalid_t2", m_awvalid_o, (mode == 0) ? 0 : 1);
            chk("skew_atx_vld_t2", atx_vld, (mode == 0) ? 1 : 0);
            ch_aw_vld = 4'b0100;
            cyc(); cyc();
            if (mode == 0) atx_rdy = 1; else m_awready_i = 1;
            cyc();
            chk("skew_idle_t5", ch_aw_rdy, 4'b0100);
            cyc();
            ch_aw_vld = '0;
            cyc(); cyc();
        end

        // Outstanding limit
        do_reset();
        for (int c = 0; c < CH; c++) set_ch(c, 32'h100 * c, 8'(c));
        ch_aw_vld = 4'hf; m_awready_i = 1; atx_rdy = 1;
        for (int k = 0; k < 8; k++) cyc();
        chk("limit_ostd4", ostd_cnt, 4);
        cyc(); cyc();
        chk("limit_no_rdy", ch_aw_rdy, 0);
        m_bvalid_i = 1; m_bid_i = 2'd2; m_bresp_i = 2'b00;
        #1 chk("limit_b_cycle_no_rdy", ch_aw_rdy, 0);
        cyc();
        m_bvalid_i = 0;
        chk("limit_done2", ch_done, 4'b0100);
        chk("limit_resume", ch_aw_rdy, 4'b0001);
        cyc();
        ch_aw_vld = '0;
        cyc(); cyc();

        // Simultaneous AW and B handshake with two outstanding
        do_reset();
        m_awready_i = 1; atx_rdy = 1;
        ch_aw_vld = 4'b0001; cyc(); cyc();
        ch_aw_vld = 4'b0010; cyc(); cyc();
        chk("simul_pre_ostd", ostd_cnt, 2);
        ch_aw_vld = 4'b0100; m_awready_i = 0;
        cyc();
        ch_aw_vld = '0; m_awready_i = 1;
        m_bvalid_i = 1; m_bid_i = 2'd0; m_bresp_i = 2'b10;
        cyc();
        m_bvalid_i = 0;
        chk("simul_ostd", ostd_cnt, 2);
        chk("simul_done", ch_done, 4'b0001);
        chk("simul_err", ch_err, 4'b0001);
        cyc(); cyc();

        // Unexpected B with nothing outstanding
        do_reset();
        m_bvalid_i = 1; m_bid_i = 2'd1; m_bresp_i = 2'b00;
        cyc();
        m_bvalid_i = 0;
        chk("unexp_set", unexp_b_err, 1);
        chk("unexp_ostd", ostd_cnt, 0);
        cyc(); cyc();
        chk("unexp_sticky", unexp_b_err, 1);

        // Asynchronous reset in the middle of an issue
        do_reset();
        set_ch(3, 32'hC000, 8'd9);
        ch_aw_vld = 4'b1000; m_awready_i = 1; atx_rdy = 0;
        cyc();
        ch_aw_vld = '0;
        cyc();
        chk("midrst_pre_ostd", ostd_cnt, 1);
        chk("midrst_pre_atx", atx_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_awvalid", m_awvalid_o, 0);
        chk("midrst_atx_vld", atx_vld, 0);
        chk("midrst_ostd", ostd_cnt, 0);
        do_reset();

        // Randomized traffic against the model
        hold = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (!hold[c] && $urandom_range(3) == 0) begin
                    hold[c] = 1'b1;
                    set_ch(c, $urandom, 8'($urandom_range(255)));
                end
            end
            ch_aw_vld   = hold;
            m_awready_i = ($urandom_range(2) != 0);
            atx_rdy     = ($urandom_range(2) != 0);
            if (ostd_q.size() > 0 && $urandom_range(2) == 0) begin
                m_bvalid_i = 1'b1;
                m_bid_i    = IDW'(ostd_q[$urandom_range(ostd_q.size() - 1)]);
                m_bresp_i  = 2'($urandom_range(3));
            end else begin
                m_bvalid_i = 1'b0;
            end
            cyc();
            if (last_g >= 0) hold[last_g] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adma_dm_aw_sched.md
Name: adma_dm_aw_sched

Overview:
Write-side transaction scheduler for the DMA data mover. It round-robin arbitrates burst requests from CH_NUM DMA channels and issues one AXI AW beat per granted burst. For the same burst it pushes the burst length into the W-channel mover's transaction FIFO. It tracks outstanding write bursts and routes B responses back to the owning channel by AWID/BID.

Parameters:
CH_NUM, 4, number of requesting DMA channels (2..16)
ATX_ID_W, 2, AXI ID width; must be >= clog2(CH_NUM); ID value = channel index
ATX_ADDR_W, 32, AXI address width
ATX_LEN_W, 8, AXI AWLEN width
ATX_NUM_OSTD, 4, maximum outstanding write bursts (AW accepted, B not yet received)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ch_awaddr  in  CH_NUM*ATX_ADDR_W  per-channel burst start address; channel i at slice [i*ATX_ADDR_W +: ATX_ADDR_W]
ch_awlen  in  CH_NUM*ATX_LEN_W  per-channel burst length (beats-1)
ch_aw_vld  in  CH_NUM  per-channel request valid
ch_aw_rdy  out  CH_NUM  per-channel request accept (one-hot or zero)
ch_done  out  CH_NUM  one-cycle pulse: B response received for channel
ch_err  out  CH_NUM  one-cycle pulse with ch_done when BRESP[1]=1 (SLVERR/DECERR)
atx_awlen  out  ATX_LEN_W  length pushed to W mover FIFO
atx_vld  out  1  W mover push valid
atx_rdy  in  1  W mover push ready
m_awid_o  out  ATX_ID_W  AXI AWID
m_awaddr_o  out  ATX_ADDR_W  AXI AWADDR
m_awlen_o  out  ATX_LEN_W  AXI AWLEN
m_awvalid_o  out  1  AXI AWVALID
m_awready_i  in  1  AXI AWREADY
m_bid_i  in  ATX_ID_W  AXI BID
m_bresp_i  in  2  AXI BRESP
m_bvalid_i  in  1  AXI BVALID
m_bready_o  out  1  AXI BREADY
ostd_cnt  out  clog2(ATX_NUM_OSTD+1)  current outstanding burst count
unexp_b_err  out  1  sticky: B received with ostd_cnt==0 or BID>=CH_NUM

Behaviour:
- Single clock clk; asynchronous active-low reset rst_n.
- Reset values: state=IDLE, rr_ptr=0, m_awvalid_o=0, atx_vld=0, ostd_cnt=0, unexp_b_err=0. ch_done and ch_err are 0. AW/atx payload registers are 0. m_bready_o=0 in reset, 1 otherwise.
- FSM has two states, IDLE and ISSUE.
- IDLE, grant condition: any ch_aw_vld and ostd_cnt < ATX_NUM_OSTD.
- IDLE, grant selection: the first requesting channel scanning from rr_ptr upward, wrapping at CH_NUM-1 to 0.
- IDLE, on grant:
  - ch_aw_rdy[g]=1 combinationally, in the same cycle.
  - Capture addr/len of g, and set awid=g.
  - Set m_awvalid_o=1 and atx_vld=1 (registered); go to ISSUE.
  - rr_ptr <= (g==CH_NUM-1) ? 0 : g+1.
- Latency: request valid at cycle t -> ch_aw_rdy at t -> AWVALID and atx_vld at t+1.
- ISSUE:
  - m_awvalid_o held until m_awready_i; atx_vld held until atx_rdy. The two handshakes are independent and may complete in the same or different cycles.
  - Payload (m_aw*_o, atx_awlen) is stable while the corresponding valid is high.
  - Return to IDLE the cycle after both handshakes are done.
  - ch_aw_rdy is all-zero in ISSUE, so at most one burst is in the scheduler at a time.
- AW handshake occurring while atx is still pending is legal. W data cannot flow until atx is pushed, so AXI ordering holds.
- Outstanding counter:
  - +1 on AW handshake, -1 on B handshake; unchanged when both occur in the same cycle.
  - In IDLE, the grant check uses the registered ostd_cnt. A same-cycle B does not free a slot until the next cycle.
- B path:
  - m_bready_o=1 after reset.
  - On B handshake with valid BID: ch_done[BID]=1 and ch_err[BID]=BRESP[1], registered, for one cycle.
  - On B with ostd_cnt==0: counter stays 0, unexp_b_err set.
  - On BID>=CH_NUM: no ch_done pulse, unexp_b_err set; the counter still decrements if nonzero.
- Channel dropping ch_aw_vld in the same cycle as grant: the grant stands (it is a handshake). Channels must hold vld until rdy.
- Reset mid-ISSUE: valids drop immediately and the counter clears. Reset mid-operation is a system-wide abort.

Decomposition:
- Package adma_pkg: BRESP encodings (OKAY, EXOKAY, SLVERR, DECERR); state enum {IDLE, ISSUE}.
- Sub-module adma_rr_arb (CH_NUM): combinational round-robin pick from req vector and rr_ptr, giving one-hot grant and grant index. It is reusable for the read-side scheduler.

Test Plan:
- Single request: ch1 vld with addr 0x1000, len 7; AWREADY and atx_rdy high.
  -> ch_aw_rdy[1] at t; AWID=1, AWADDR=0x1000, AWLEN=7, atx_awlen=7 at t+1; back to IDLE at t+2; ostd_cnt=1.
- Fairness: all 4 channels held valid, ready always high.
  -> grant order 0,1,2,3,0 with a 2-cycle issue cadence.
- Skewed handshakes, two cases:
  - AWREADY at t+1, atx_rdy at t+4 -> AWVALID low after t+1, atx_vld high until t+4, IDLE at t+5.
  - The reverse order gives the same IDLE timing.
- Outstanding limit: 4 bursts issued with no B.
  -> ostd_cnt=4 and no further ch_aw_rdy. One B with BID=2 -> ch_done[2] pulse; grant resumes the following cycle.
- Simultaneous AW and B handshake with ostd_cnt=2 -> ostd_cnt stays 2.
  - BRESP=2'b10 on that B -> ch_err and ch_done pulse together for that BID.
- Unexpected B: BVALID with ostd_cnt=0 -> unexp_b_err=1 (sticky), counter stays 0.
- Reset mid-ISSUE: assert reset -> all valids and the counter are 0 asynchronously.
